// File: rtl/adder_harness.sv
// rtl/adder_harness.sv - valid/ready driver and checker around a 6-bit combinational adder
// Includes an autonomous exhaustive 64x64 sweep with a saturating mismatch counter.
module adder_harness #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       a,
    input  logic [5:0]       b,
    input  logic             start,
    output logic [5:0]       adder_x,
    output logic [5:0]       adder_y,
    input  logic [5:0]       adder_s,
    input  logic             adder_ov,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       sum,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy,
    output logic             done
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, OUT} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [5:0]       x_q, x_d, y_q, y_d;
    logic [5:0]       i_q, i_d, j_q, j_d;
    logic [6:0]       sum_q, sum_d;
    logic             mism_q, mism_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             oval_q, oval_d;

    logic       settle_last;
    logic       last_pair;
    logic [6:0] result;
    logic [6:0] reference;
    logic       res_bad;

    assign settle_last = (settle_q == SW'(SETTLE - 1));
    assign last_pair   = (&i_q) & (&j_q);
    assign result      = {adder_ov, adder_s};
    assign reference   = {1'b0, x_q} + {1'b0, y_q};
    assign res_bad     = (result != reference);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start || in_valid) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = (busy_q && !last_pair) ? DRIVE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        settle_d = settle_q;
        x_d      = x_q;
        y_d      = y_q;
        i_d      = i_q;
        j_d      = j_q;
        sum_d    = sum_q;
        mism_d   = mism_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        oval_d   = oval_q;
        case (state_q)
            IDLE: begin
                // start has priority; a simultaneously offered pair stays unconsumed
                if (start) begin
                    err_d    = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    x_d      = '0;
                    y_d      = '0;
                    settle_d = '0;
                end else if (in_valid) begin
                    x_d      = a;
                    y_d      = b;
                    settle_d = '0;
                end
            end
            DRIVE: begin
                if (settle_last) begin
                    sum_d  = result;
                    mism_d = res_bad;
                    oval_d = 1'b1;
                    if (res_bad && (err_q != {CNT_W{1'b1}})) begin
                        err_d = err_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    oval_d = 1'b0;
                    if (busy_q) begin
                        if (last_pair) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            j_d      = j_q + 6'd1;
                            i_d      = (&j_q) ? i_q + 6'd1 : i_q;
                            x_d      = i_d;
                            y_d      = j_d;
                            settle_d = '0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            sum_q    <= '0;
            mism_q   <= 1'b0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oval_q   <= 1'b0;
        end else begin
            settle_q <= settle_d;
            x_q      <= x_d;
            y_q      <= y_d;
            i_q      <= i_d;
            j_q      <= j_d;
            sum_q    <= sum_d;
            mism_q   <= mism_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            oval_q   <= oval_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        adder_x   = x_q;
        adder_y   = y_q;
        out_valid = oval_q;
        sum       = sum_q;
        mismatch  = mism_q;
        err_cnt   = err_q;
        busy      = busy_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_adder_harness.sv
// tb/tb_adder_harness.sv - scoreboard bench for adder_harness with behavioural adder models
// Two instances: default parameters, and SETTLE=2/CNT_W=4 for counter saturation.
module tb_adder_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid0, in_ready0, start0, out_valid0, out_ready0, mis0, busy0, done0, ov0, f0;
    logic [5:0]  a0, b0, x0, y0, s0;
    logic [6:0]  sum0, add0;
    logic [12:0] err0;

    logic        in_valid1, in_ready1, start1, out_valid1, out_ready1, mis1, busy1, done1, ov1;
    logic [5:0]  a1, b1, x1, y1, s1;
    logic [6:0]  sum1, add1;
    logic [3:0]  err1;

    // Adder models; f0 forces s0 stuck-at-0, instance 1 always carries that fault
    assign add0 = {1'b0, x0} + {1'b0, y0};
    assign s0   = add0[5:0] & {5'h1f, ~f0};
    assign ov0  = add0[6];
    assign add1 = {1'b0, x1} + {1'b0, y1};
    assign s1   = add1[5:0] & 6'h3e;
    assign ov1  = add1[6];

    adder_harness u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .start(start0), .adder_x(x0), .adder_y(y0),
        .adder_s(s0), .adder_ov(ov0), .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .mismatch(mis0), .err_cnt(err0), .busy(busy0), .done(done0)
    );

    adder_harness #(.SETTLE(2), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .start(start1), .adder_x(x1), .adder_y(y1),
        .adder_s(s1), .adder_ov(ov1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .mismatch(mis1), .err_cnt(err1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready0) begin
            logic [7:0] e;
            hs_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got result %0d with no expected entry", sum0);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", int'(sum0), int'(e[6:0]));
                chk("sb_mismatch", int'(mis0), int'(e[7]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair; returns the number of edges from acceptance to out_valid
    task automatic issue(input logic [5:0] a, input logic [5:0] b, output int lat);
        in_valid0 = 1'b1;
        a0 = a;
        b0 = b;
        tick();
        in_valid0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    typedef struct { logic [5:0] a; logic [5:0] b; logic [6:0] s; } vec_t;
    vec_t vecs[5] = '{'{6'd0, 6'd0, 7'd0}, '{6'd1, 6'd62, 7'd63}, '{6'd32, 6'd32, 7'd64},
                      '{6'd45, 6'd27, 7'd72}, '{6'd63, 6'd1, 7'd64}};

    initial begin
        int lat;
        int n;
        logic ir_bad;
        rst_n = 1'b0;
        in_valid0 = 0; a0 = 0; b0 = 0; start0 = 0; out_ready0 = 0; f0 = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; start1 = 0; out_ready1 = 1;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready0), 0);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_sum", int'(sum0), 0);
        chk("rst_err_cnt", int'(err0), 0);
        chk("rst_busy_done", int'({busy0, done0}), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_in_ready", int'(in_ready0), 1);

        // Reset while a result is held in OUT
        issue(6'd5, 6'd7, lat);
        chk("midout_sum", int'(sum0), 12);
        chk("midout_valid", int'(out_valid0), 1);
        rst_n = 1'b0;
        tick();
        chk("midout_rst_valid", int'(out_valid0), 0);
        chk("midout_rst_sum", int'(sum0), 0);
        chk("midout_rst_xy", int'({x0, y0}), 0);
        chk("midout_rst_in_ready", int'(in_ready0), 0);
        rst_n = 1'b1;
        tick();
        chk("midout_in_ready_after", int'(in_ready0), 1);

        // Single op at the arithmetic maximum
        out_ready0 = 1'b1;
        sb.push_back({1'b0, 7'd126});
        issue(6'd63, 6'd63, lat);
        chk("max_latency", lat, 1);
        tick();
        chk("max_err_cnt", int'(err0), 0);
        chk("max_released", int'(out_valid0), 0);

        foreach (vecs[k]) begin
            sb.push_back({1'b0, vecs[k].s});
            issue(vecs[k].a, vecs[k].b, lat);
            chk("vec_latency", lat, 1);
            tick();
        end

        // Backpressure: result and operands held until out_ready
        out_ready0 = 1'b0;
        issue(6'd10, 6'd20, lat);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_sum", int'(sum0), 30);
            chk("bp_xy", int'({x0, y0}), int'({6'd10, 6'd20}));
            chk("bp_in_ready", int'(in_ready0), 0);
            chk("bp_valid", int'(out_valid0), 1);
        end
        sb.push_back({1'b0, 7'd30});
        out_ready0 = 1'b1;
        tick();
        chk("bp_release", int'(out_valid0), 0);
        chk("bp_idle_ready", int'(in_ready0), 1);

        // Exhaustive sweep with s0 stuck-at-0; start collides with an offered pair
        f0 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                sb.push_back({1'b0, 7'(i + j)} & 8'h7e | {7'(i + j) & 8'h01, 7'h00});
            end
        end
        hs_cnt = 0;
        start0 = 1'b1;
        in_valid0 = 1'b1;
        a0 = 6'd1;
        b0 = 6'd1;
        tick();
        start0 = 1'b0;
        in_valid0 = 1'b0;
        chk("sweep_busy", int'(busy0), 1);
        chk("sweep_first_xy", int'({x0, y0}), 0);
        ir_bad = 1'b0;
        n = 0;
        while (n < 20000) begin
            if (done0) break;
            if (in_ready0) ir_bad = 1'b1;
            tick();
            n++;
        end
        chk("sweep_done", int'(done0), 1);
        chk("sweep_busy_clear", int'(busy0), 0);
        chk("sweep_in_ready_low", int'(ir_bad), 0);
        chk("sweep_err_cnt", int'(err0), 2048);
        chk("sweep_handshakes", hs_cnt, 4096);
        chk("sweep_sb_drained", sb.size(), 0);

        // Single ops do not clear err_cnt
        f0 = 1'b0;
        sb.push_back({1'b0, 7'd7});
        issue(6'd3, 6'd4, lat);
        tick();
        chk("keep_err_cnt", int'(err0), 2048);
        f0 = 1'b1;
        sb.push_back({1'b1, 7'd2});
        issue(6'd1, 6'd2, lat);
        tick();
        chk("incr_err_cnt", int'(err0), 2049);
        chk("done_sticky", int'(done0), 1);

        // Saturation on the 4-bit counter instance
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20000) begin
            tick();
            n++;
        end
        chk("sat_done", int'(done1), 1);
        chk("sat_err_cnt", int'(err1), 15);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("sat_restart_clear", int'(err1), 0);
        chk("sat_restart_done", int'(done1), 0);
        chk("sat_restart_busy", int'(busy1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
